test_usart: RTL and testbench



---
 rtl/test_usart_pkg.sv | 12 +
 rtl/usart_rx.sv | 74 +++++++
 rtl/test_usart.sv | 72 +++++++
 tb/tb_test_usart.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/test_usart_pkg.sv
// test_usart_pkg: shared constants, FSM state types and parity helper for the test_usart block.
package test_usart_pkg;
    localparam int BIT_CYCLES_DEF = 8;
    localparam int FRAME_BITS = 11;

    typedef enum logic [1:0] {TX_ARMED, TX_SEND, TX_DONE} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction
endpackage

// File: rtl/usart_rx.sv
// usart_rx: frame receiver with input synchronizer, own phase counter and mid-bit sampling.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   clr    synchronous receiver clear (idles the FSM, drops ready and perr)
//   rx     serial input, idle high
//   data   last correctly framed byte
//   perr   parity mismatch of the last accepted frame
//   ready  a frame has been accepted since the last clear
module usart_rx import test_usart_pkg::*; #(
    parameter int BIT_CYCLES = BIT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       rx,
    output logic [7:0] data,
    output logic       perr,
    output logic       ready
);
    localparam int CW = $clog2(BIT_CYCLES);
    rx_state_t st, st_nx;
    logic s1, rs, par, mid, full;
    logic [CW-1:0] pc;
    logic [2:0] idx;
    logic [7:0] sh;
    assign mid = pc == CW'(BIT_CYCLES / 2 - 1);
    assign full = pc == CW'(BIT_CYCLES - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) st <= RX_IDLE;
        else st <= st_nx;
    always_comb begin
        st_nx = st;
        case (st)
            RX_IDLE:   st_nx = rs ? RX_IDLE : RX_START;
            RX_START:  st_nx = !mid ? RX_START : rs ? RX_IDLE : RX_DATA;
            RX_DATA:   st_nx = (full && idx == 3'd7) ? RX_PARITY : RX_DATA;
            RX_PARITY: st_nx = full ? RX_STOP : RX_PARITY;
            RX_STOP:   st_nx = full ? RX_IDLE : RX_STOP;
            default:   st_nx = RX_IDLE;
        endcase
        if (clr) st_nx = RX_IDLE;
    end
    // pc restarts at the start-bit centre so later samples land mid-bit on each wrap
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s1 <= 1'b1;
            rs <= 1'b1;
            pc <= '0;
            idx <= '0;
            sh <= '0;
            par <= 1'b0;
            data <= '0;
            perr <= 1'b0;
            ready <= 1'b0;
        end else begin
            s1 <= rx;
            rs <= s1;
            pc <= (clr || st == RX_IDLE || (st == RX_START && mid)) ? '0 : pc + 1'b1;
            if (st == RX_IDLE) idx <= '0;
            if (st == RX_DATA && full) begin
                sh <= {rs, sh[7:1]};
                idx <= idx + 3'd1;
            end
            if (st == RX_PARITY && full) par <= rs;
            if (clr) begin
                ready <= 1'b0;
                perr <= 1'b0;
            end else if (st == RX_STOP && full && rs) begin
                data <= sh;
                perr <= par != even_par(sh);
                ready <= 1'b1;
            end
        end
endmodule

// File: rtl/test_usart.sv
// test_usart: one-shot frame transmitter, baud-phase clock and receiver.
//   CLK         system clock
//   CLR         asynchronous active-low reset; each release sends one frame
//   CLR_Rec     synchronous receiver clear
//   Data_Tx     byte latched on the first edge after CLR rises
//   Rx / Tx     serial input / output, idle high
//   CLK_B       baud phase: low first half of each bit, high second half
//   Data_Rx     last correctly framed received byte
//   parity_err  parity mismatch of the last accepted frame
//   Data_Ready  a frame has been accepted since the last clear
module test_usart import test_usart_pkg::*; #(
    parameter int BIT_CYCLES = BIT_CYCLES_DEF
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       CLR_Rec,
    input  logic [7:0] Data_Tx,
    input  logic       Rx,
    output logic       Tx,
    output logic       CLK_B,
    output logic [7:0] Data_Rx,
    output logic       parity_err,
    output logic       Data_Ready
);
    localparam int CW = $clog2(BIT_CYCLES);
    tx_state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [9:0] sh;
    logic [3:0] left;
    logic bnd;
    assign bnd = cnt == '0;
    always_ff @(posedge CLK or negedge CLR)
        if (!CLR) begin
            cnt <= '0;
            CLK_B <= 1'b0;
        end else begin
            cnt <= cnt + 1'b1;
            CLK_B <= cnt[CW-1];
        end
    always_ff @(posedge CLK or negedge CLR)
        if (!CLR) state <= TX_ARMED;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        state_nx = state == TX_ARMED ? TX_SEND :
                   (state == TX_SEND && bnd && left == 4'd0) ? TX_DONE : state;
    end
    // ARMED always coincides with cnt==0, so the start bit begins on a counter wrap
    always_ff @(posedge CLK or negedge CLR)
        if (!CLR) begin
            Tx <= 1'b1;
            sh <= '0;
            left <= '0;
        end else if (state == TX_ARMED) begin
            Tx <= 1'b0;
            sh <= {1'b1, even_par(Data_Tx), Data_Tx};
            left <= 4'(FRAME_BITS - 1);
        end else if (state == TX_SEND && bnd) begin
            Tx <= left == 4'd0 ? 1'b1 : sh[0];
            sh <= {1'b0, sh[9:1]};
            if (left != 4'd0) left <= left - 4'd1;
        end
    usart_rx #(.BIT_CYCLES(BIT_CYCLES)) u_rx (
        .clk(CLK),
        .rst_n(CLR),
        .clr(CLR_Rec),
        .rx(Rx),
        .data(Data_Rx),
        .perr(parity_err),
        .ready(Data_Ready)
    );
endmodule

// File: tb/tb_test_usart.sv
// tb_test_usart: scoreboard bench for test_usart with loopback and externally driven frames.
`timescale 1ns/1ps
module tb_test_usart;
    typedef struct packed {logic [7:0] d; logic pe;} exp_t;
    logic clk = 0, clr = 0, clr_rec = 0, rx_drv = 1, lb = 1;
    logic [7:0] data_tx = 0;
    logic tx, clk_b, perr, rdy, rx;
    logic [7:0] data_rx;
    int n_pass = 0, n_total = 0, cyc = 0;
    exp_t q[$];
    exp_t e;
    logic prev_rdy = 0;
    assign rx = lb ? tx : rx_drv;

    test_usart dut (
        .CLK(clk), .CLR(clr), .CLR_Rec(clr_rec), .Data_Tx(data_tx), .Rx(rx),
        .Tx(tx), .CLK_B(clk_b), .Data_Rx(data_rx), .parity_err(perr), .Data_Ready(rdy)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic par_of(input logic [7:0] d);
        return ($countones(d) % 2) == 1;
    endfunction

    // bit k of the 11-bit line frame: start, d0..d7, even parity, stop
    function automatic logic frame_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (k == 9) return par_of(d);
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic pulse_clr_rec;
        @(negedge clk) clr_rec = 1;
        @(negedge clk) clr_rec = 0;
    endtask

    task automatic send_ext(input logic [7:0] d, input logic flip, input logic stop);
        for (int k = 0; k < 11; k++) begin
            rx_drv = k == 10 ? stop : k == 9 ? frame_bit(d, k) ^ flip : frame_bit(d, k);
            repeat (8) @(negedge clk);
        end
        rx_drv = 1;
        repeat (24) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rdy && !prev_rdy) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_frame: got data %0h with none expected", data_rx);
            end else begin
                e = q.pop_front();
                chk("rx_data", {24'b0, data_rx}, {24'b0, e.d});
                chk("rx_parity_err", {31'b0, perr}, {31'b0, e.pe});
            end
        end
        prev_rdy = rdy;
    end

    initial begin
        int fall_cyc, rise_cyc, lat;
        logic [7:0] v, last_v;
        logic f;
        #1000;
        chk("rst_tx", {31'b0, tx}, 1);
        chk("rst_clk_b", {31'b0, clk_b}, 0);
        chk("rst_ready", {31'b0, rdy}, 0);
        chk("rst_data_rx", {24'b0, data_rx}, 0);
        chk("rst_parity_err", {31'b0, perr}, 0);

        @(negedge clk);
        data_tx = 8'h5A;
        clr = 1;
        q.push_back(exp_t'{8'h5A, 1'b0});
        fall_cyc = -1;
        rise_cyc = -1;
        for (int k = 0; k < 11; k++)
            for (int c = 0; c < 8; c++) begin
                @(posedge clk);
                #1;
                if (k == 0 && c == 0) fall_cyc = cyc;
                if (k == 0 && c == 2) data_tx = 8'hFF;
                chk($sformatf("tx_bit%0d_c%0d", k, c), {31'b0, tx}, {31'b0, frame_bit(8'h5A, k)});
                chk($sformatf("clk_b_bit%0d_c%0d", k, c), {31'b0, clk_b}, c >= 4 ? 1 : 0);
                if (rdy && rise_cyc < 0) rise_cyc = cyc;
            end
        for (int i = 0; i < 20 && rise_cyc < 0; i++) begin
            @(posedge clk);
            #1;
            if (rdy) rise_cyc = cyc;
        end
        lat = rise_cyc - fall_cyc;
        n_total++;
        if (rise_cyc >= 0 && lat >= 85 && lat <= 89) n_pass++;
        else $display("FAIL ready_latency: got %0d cycles (rise %0d) expected 85..89", lat, rise_cyc);

        last_v = 8'h5A;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk) clr = 0;
            #2500;
            @(negedge clk);
            v = i < 4 ? 8'(i + 1) : 8'($urandom);
            data_tx = v;
            clr = 1;
            q.push_back(exp_t'{v, 1'b0});
            repeat (3) @(negedge clk);
            data_tx = 8'($urandom);
            repeat (122) @(negedge clk);
            chk("window_ready", {31'b0, rdy}, 1);
            last_v = v;
        end

        lb = 0;
        pulse_clr_rec;
        chk("clr_rec_ready", {31'b0, rdy}, 0);
        chk("clr_rec_perr", {31'b0, perr}, 0);
        chk("clr_rec_keep_data", {24'b0, data_rx}, {24'b0, last_v});
        q.push_back(exp_t'{8'h07, 1'b1});
        send_ext(8'h07, 1'b1, 1'b1);
        chk("bad_par_ready", {31'b0, rdy}, 1);
        chk("bad_par_data", {24'b0, data_rx}, 32'h07);
        chk("bad_par_perr", {31'b0, perr}, 1);
        send_ext(8'h3C, 1'b0, 1'b0);
        chk("framing_ready", {31'b0, rdy}, 1);
        chk("framing_data", {24'b0, data_rx}, 32'h07);
        chk("framing_perr", {31'b0, perr}, 1);
        pulse_clr_rec;
        chk("clr_rec2_ready", {31'b0, rdy}, 0);
        chk("clr_rec2_perr", {31'b0, perr}, 0);
        chk("clr_rec2_keep_data", {24'b0, data_rx}, 32'h07);
        rx_drv = 0;
        repeat (2) @(negedge clk);
        rx_drv = 1;
        repeat (100) @(negedge clk);
        chk("glitch_ready", {31'b0, rdy}, 0);
        chk("glitch_data", {24'b0, data_rx}, 32'h07);
        for (int i = 0; i < 6; i++) begin
            v = 8'($urandom);
            f = 1'($urandom_range(0, 1));
            pulse_clr_rec;
            q.push_back(exp_t'{v, f});
            send_ext(v, f, 1'b1);
        end

        lb = 1;
        @(negedge clk) clr = 0;
        repeat (10) @(negedge clk);
        data_tx = 8'($urandom) & 8'hF7;
        clr = 1;
        repeat (36) @(negedge clk);
        chk("tx_mid_frame", {31'b0, tx}, 0);
        #3 clr = 0;
        #1;
        chk("abort_tx", {31'b0, tx}, 1);
        chk("abort_ready", {31'b0, rdy}, 0);
        repeat (150) @(negedge clk);
        chk("abort_tx_hold", {31'b0, tx}, 1);
        chk("abort_no_ready", {31'b0, rdy}, 0);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
